// File: rtl/pe_ctrl_pkg.sv
// Shared state encoding and latency defaults for the PE vector sequencer.
// The default output latency follows the adder tree depth plus the MAC flush.
package pe_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_W,
        COMPUTE,
        FLUSH,
        DRAIN,
        DONE
    } state_e;

    localparam int NUM_OF_CHANNEL = 32;
    localparam int DEF_OUT_LAT    = $clog2(NUM_OF_CHANNEL) + 1;

endpackage

// File: rtl/valid_delay_line.sv
// 1-bit valid shift register that tracks flushed outputs through the adder tree.
// pending is high while a valid is in flight and has not yet reached the tail.
module valid_delay_line #(
    parameter int DEPTH = 6
) (
    input  logic clk,
    input  logic rstN,
    input  logic push,
    output logic tail,
    output logic pending
);

    logic [DEPTH-1:0] sr;

    generate
        if (DEPTH == 1) begin : g_one
            always_ff @(posedge clk or negedge rstN) begin
                if (!rstN) sr <= '0;
                else       sr <= push;
            end
            assign pending = 1'b0;
        end else begin : g_many
            always_ff @(posedge clk or negedge rstN) begin
                if (!rstN) sr <= '0;
                else       sr <= {sr[DEPTH-2:0], push};
            end
            assign pending = |sr[DEPTH-2:0];
        end
    endgenerate

    assign tail = sr[DEPTH-1];

endmodule

// File: rtl/pe_vector_ctrl.sv
// Sequencer for one channel-parallel PE vector: weight load, iact streaming,
// MAC flush and output-valid tracking through the adder tree.
module pe_vector_ctrl
    import pe_ctrl_pkg::*;
#(
    parameter int WEIGHTS_ADDR_BITWIDTH = 4,
    parameter int OUT_CNT_BITWIDTH      = 16,
    parameter int OUT_LAT               = DEF_OUT_LAT
) (
    input  logic                             clk,
    input  logic                             rstN,
    input  logic                             start,
    input  logic                             cfg_reload_wght,
    input  logic [WEIGHTS_ADDR_BITWIDTH-1:0] cfg_k_len_m1,
    input  logic [OUT_CNT_BITWIDTH-1:0]      cfg_num_out_m1,
    input  logic                             wght_valid,
    output logic                             wght_ready,
    input  logic                             iact_valid,
    output logic                             iact_ready,
    output logic                             en_regfile_wght,
    output logic                             we_regfile_wght,
    output logic [WEIGHTS_ADDR_BITWIDTH-1:0] wr_addr_wght,
    output logic [WEIGHTS_ADDR_BITWIDTH-1:0] rd_addr_wght,
    output logic                             en_MAC_din,
    output logic                             en_MAC_dout,
    output logic                             oact_valid,
    output logic                             busy,
    output logic                             done
);

    localparam int W = WEIGHTS_ADDR_BITWIDTH;
    localparam int O = OUT_CNT_BITWIDTH;

    state_e         state, state_d;
    logic [W-1:0]   w_q, w_d;
    logic [W-1:0]   k_q, k_d;
    logic [O-1:0]   o_q, o_d;
    logic [W-1:0]   k_len_q;
    logic [O-1:0]   num_out_q;
    logic           push;
    logic           tail;
    logic           pending;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state     <= IDLE;
            w_q       <= '0;
            k_q       <= '0;
            o_q       <= '0;
            k_len_q   <= '0;
            num_out_q <= '0;
        end else begin
            state <= state_d;
            w_q   <= w_d;
            k_q   <= k_d;
            o_q   <= o_d;
            if (state == IDLE && start) begin
                k_len_q   <= cfg_k_len_m1;
                num_out_q <= cfg_num_out_m1;
            end
        end
    end

    always_comb begin
        state_d         = state;
        w_d             = w_q;
        k_d             = k_q;
        o_d             = o_q;
        wght_ready      = 1'b0;
        iact_ready      = 1'b0;
        en_regfile_wght = 1'b0;
        we_regfile_wght = 1'b0;
        en_MAC_din      = 1'b0;
        en_MAC_dout     = 1'b0;
        push            = 1'b0;
        done            = 1'b0;
        busy            = 1'b1;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_d = cfg_reload_wght ? LOAD_W : COMPUTE;
                    w_d     = '0;
                    k_d     = '0;
                    o_d     = '0;
                end
            end
            LOAD_W: begin
                wght_ready = 1'b1;
                if (wght_valid) begin
                    en_regfile_wght = 1'b1;
                    we_regfile_wght = 1'b1;
                    if (w_q == k_len_q) begin
                        w_d     = '0;
                        state_d = COMPUTE;
                    end else begin
                        w_d = w_q + 1'b1;
                    end
                end
            end
            COMPUTE: begin
                iact_ready = 1'b1;
                if (iact_valid) begin
                    en_regfile_wght = 1'b1;
                    en_MAC_din      = 1'b1;
                    if (k_q == k_len_q) begin
                        k_d     = '0;
                        state_d = FLUSH;
                    end else begin
                        k_d = k_q + 1'b1;
                    end
                end
            end
            FLUSH: begin
                en_MAC_dout = 1'b1;
                push        = 1'b1;
                if (o_q == num_out_q) begin
                    state_d = DRAIN;
                end else begin
                    o_d     = o_q + 1'b1;
                    state_d = COMPUTE;
                end
            end
            // Leave once only the tail bit can still be set, so done
            // lands on the cycle right after the last oact_valid.
            DRAIN: begin
                if (!pending) state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    valid_delay_line #(
        .DEPTH(OUT_LAT)
    ) u_dly (
        .clk    (clk),
        .rstN   (rstN),
        .push   (push),
        .tail   (tail),
        .pending(pending)
    );

    assign oact_valid   = tail;
    assign rd_addr_wght = k_q;
    assign wr_addr_wght = w_q;

endmodule

// File: tb/tb_pe_vector_ctrl.sv
// Directed bench for pe_vector_ctrl: load, compute, stalls, K boundaries,
// mid-job reset and ignored start, with a negedge monitor as scoreboard.
module tb_pe_vector_ctrl;

    localparam int W   = 4;
    localparam int OCW = 16;
    localparam int LAT = 6;

    logic           clk = 1'b0;
    logic           rstN = 1'b1;
    logic           start = 1'b0;
    logic           cfg_reload_wght = 1'b0;
    logic [W-1:0]   cfg_k_len_m1 = '0;
    logic [OCW-1:0] cfg_num_out_m1 = '0;
    logic           wght_valid = 1'b0;
    logic           iact_valid = 1'b0;
    logic           wght_ready, iact_ready;
    logic           en_regfile_wght, we_regfile_wght;
    logic [W-1:0]   wr_addr_wght, rd_addr_wght;
    logic           en_MAC_din, en_MAC_dout;
    logic           oact_valid, busy, done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int kk = 9;
    logic clr = 1'b0;
    int n_wr = 0, n_din = 0, n_dout = 0, n_oact = 0, n_done = 0;
    int bad_addr = 0, bad_lat = 0, bad_ctl = 0;
    int first_dout = -1, last_dout = 0, last_oact = 0;
    int exp_k = 0, exp_w = 0;
    logic [LAT-1:0] hist = '0;

    pe_vector_ctrl #(
        .WEIGHTS_ADDR_BITWIDTH(W),
        .OUT_CNT_BITWIDTH(OCW),
        .OUT_LAT(LAT)
    ) dut (
        .clk            (clk),
        .rstN           (rstN),
        .start          (start),
        .cfg_reload_wght(cfg_reload_wght),
        .cfg_k_len_m1   (cfg_k_len_m1),
        .cfg_num_out_m1 (cfg_num_out_m1),
        .wght_valid     (wght_valid),
        .wght_ready     (wght_ready),
        .iact_valid     (iact_valid),
        .iact_ready     (iact_ready),
        .en_regfile_wght(en_regfile_wght),
        .we_regfile_wght(we_regfile_wght),
        .wr_addr_wght   (wr_addr_wght),
        .rd_addr_wght   (rd_addr_wght),
        .en_MAC_din     (en_MAC_din),
        .en_MAC_dout    (en_MAC_dout),
        .oact_valid     (oact_valid),
        .busy           (busy),
        .done           (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (clr) begin
            n_wr = 0; n_din = 0; n_dout = 0; n_oact = 0; n_done = 0;
            bad_addr = 0; bad_lat = 0; bad_ctl = 0;
            first_dout = -1; last_dout = 0; last_oact = 0;
        end
        if (!rstN) begin
            hist = '0; exp_k = 0; exp_w = 0;
        end else begin
            if (oact_valid !== hist[LAT-1]) bad_lat++;
            hist = {hist[LAT-2:0], en_MAC_dout};
            if (we_regfile_wght) begin
                n_wr++;
                if (wr_addr_wght !== W'(exp_w)) bad_addr++;
                exp_w = (exp_w + 1) % kk;
            end
            if (en_MAC_din) begin
                n_din++;
                if (rd_addr_wght !== W'(exp_k)) bad_addr++;
                exp_k = (exp_k + 1) % kk;
            end
            if (we_regfile_wght && (!wght_valid || !en_regfile_wght)) bad_ctl++;
            if (en_MAC_din && (!iact_valid || !en_regfile_wght || we_regfile_wght)) bad_ctl++;
            if (en_regfile_wght && !we_regfile_wght && !en_MAC_din) bad_ctl++;
            if (wght_ready && iact_ready) bad_ctl++;
            if (en_MAC_dout && iact_ready) bad_ctl++;
            if (en_MAC_dout) begin
                if (first_dout < 0) first_dout = cyc;
                last_dout = cyc;
                n_dout++;
            end
            if (oact_valid) begin
                n_oact++;
                last_oact = cyc;
            end
            if (done) n_done++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input int exp);
        checks++;
        assert (obs === 32'(exp)) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    task automatic launch(input logic rl, input int klm1, input int nom1, output int s);
        cfg_reload_wght = rl;
        cfg_k_len_m1    = W'(klm1);
        cfg_num_out_m1  = OCW'(nom1);
        kk    = klm1 + 1;
        start = 1'b1;
        s     = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int bound, output int dc);
        int n = 0;
        while (done !== 1'b1 && n < bound) begin
            tick();
            n++;
        end
        chk(tag, 32'(done), 1);
        dc = cyc;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_rd"}, 32'(rd_addr_wght), 0);
        chk({tag, "_wr"}, 32'(wr_addr_wght), 0);
        chk({tag, "_wrdy"}, 32'(wght_ready), 0);
        chk({tag, "_irdy"}, 32'(iact_ready), 0);
        chk({tag, "_en"}, 32'(en_regfile_wght), 0);
        chk({tag, "_we"}, 32'(we_regfile_wght), 0);
        chk({tag, "_din"}, 32'(en_MAC_din), 0);
        chk({tag, "_dout"}, 32'(en_MAC_dout), 0);
        chk({tag, "_oact"}, 32'(oact_valid), 0);
    endtask

    initial begin
        int s, dc, n;

        // reset
        #1 rstN = 1'b0;
        #2 chk_idle_outputs("rst_async");
        repeat (2) tick();
        chk_idle_outputs("rst_held");
        rstN = 1'b1;
        tick();
        clear_stats();

        // T1: weight load, K=9
        wght_valid = 1'b1;
        launch(1'b1, 8, 0, s);
        chk("t1_wready", 32'(wght_ready), 1);
        n = 0;
        while (iact_ready !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        chk("t1_load_cycles", 32'(n), 9);
        chk("t1_n_wr", 32'(n_wr), 9);
        wght_valid = 1'b0;
        iact_valid = 1'b1;
        wait_done("t1_done", 100, dc);
        chk("t1_done_cyc", 32'(dc - s), 26);
        chk("t1_n_din", 32'(n_din), 9);
        chk("t1_n_dout", 32'(n_dout), 1);
        chk("t1_n_oact", 32'(n_oact), 1);
        tick();
        chk("t1_busy_after", 32'(busy), 0);
        chk("t1_done_pulse", 32'(done), 0);
        chk("t1_bad_addr", 32'(bad_addr), 0);
        chk("t1_bad_ctl", 32'(bad_ctl), 0);

        // T2: four outputs, resident weights, full rate
        clear_stats();
        launch(1'b0, 8, 3, s);
        wait_done("t2_done", 300, dc);
        chk("t2_done_cyc", 32'(dc - s), 47);
        chk("t2_done_after_oact", 32'(dc - last_oact), 1);
        chk("t2_first_dout", 32'(first_dout - s), 10);
        chk("t2_dout_span", 32'(last_dout - first_dout), 30);
        chk("t2_n_din", 32'(n_din), 36);
        chk("t2_n_dout", 32'(n_dout), 4);
        chk("t2_n_oact", 32'(n_oact), 4);
        chk("t2_n_wr", 32'(n_wr), 0);
        chk("t2_bad_addr", 32'(bad_addr), 0);
        chk("t2_bad_lat", 32'(bad_lat), 0);
        tick();

        // T3: random valid gaps on both buses
        clear_stats();
        iact_valid = 1'b0;
        launch(1'b1, 8, 3, s);
        n = 0;
        while (done !== 1'b1 && n < 3000) begin
            wght_valid = 1'($urandom_range(0, 1));
            iact_valid = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        chk("t3_done", 32'(done), 1);
        tick();
        chk("t3_n_wr", 32'(n_wr), 9);
        chk("t3_n_din", 32'(n_din), 36);
        chk("t3_n_dout", 32'(n_dout), 4);
        chk("t3_n_oact", 32'(n_oact), 4);
        chk("t3_n_done", 32'(n_done), 1);
        chk("t3_bad_addr", 32'(bad_addr), 0);
        chk("t3_bad_lat", 32'(bad_lat), 0);
        chk("t3_bad_ctl", 32'(bad_ctl), 0);

        // T4a: K=1, every beat flushes
        wght_valid = 1'b1;
        iact_valid = 1'b1;
        clear_stats();
        launch(1'b0, 0, 4, s);
        wait_done("t4a_done", 200, dc);
        chk("t4a_done_cyc", 32'(dc - s), 17);
        chk("t4a_n_din", 32'(n_din), 5);
        chk("t4a_n_dout", 32'(n_dout), 5);
        chk("t4a_bad_addr", 32'(bad_addr), 0);
        tick();

        // T4b: K=16, address wraps at 4 bits
        clear_stats();
        launch(1'b1, 15, 1, s);
        wait_done("t4b_done", 300, dc);
        chk("t4b_done_cyc", 32'(dc - s), 57);
        chk("t4b_n_wr", 32'(n_wr), 16);
        chk("t4b_n_din", 32'(n_din), 32);
        chk("t4b_n_dout", 32'(n_dout), 2);
        chk("t4b_bad_addr", 32'(bad_addr), 0);
        chk("t4b_bad_lat", 32'(bad_lat), 0);
        tick();

        // T5: reset mid-compute, then restart with a stray start
        wght_valid = 1'b0;
        clear_stats();
        launch(1'b0, 8, 0, s);
        n = 0;
        while (rd_addr_wght !== 4'd5 && n < 20) begin
            tick();
            n++;
        end
        chk("t5_k5", 32'(rd_addr_wght), 5);
        #2 rstN = 1'b0;
        #1 chk_idle_outputs("t5_rst");
        repeat (3) tick();
        chk("t5_no_done", 32'(n_done), 0);
        chk("t5_no_flush", 32'(n_dout), 0);
        rstN = 1'b1;
        tick();
        clear_stats();
        launch(1'b0, 8, 0, s);
        repeat (3) tick();
        cfg_k_len_m1    = 4'd2;
        cfg_reload_wght = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("t5_done", 200, dc);
        chk("t5_done_cyc", 32'(dc - s), 17);
        tick();
        chk("t5_n_din", 32'(n_din), 9);
        chk("t5_n_dout", 32'(n_dout), 1);
        chk("t5_n_oact", 32'(n_oact), 1);
        chk("t5_n_done", 32'(n_done), 1);
        chk("t5_n_wr", 32'(n_wr), 0);
        chk("t5_bad_addr", 32'(bad_addr), 0);
        chk("t5_bad_ctl", 32'(bad_ctl), 0);
        chk("t5_busy_after", 32'(busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
